// File: rtl/ex_mem_datapath_if.sv
// Signal bundle between the ID/EX forwarding stage and the EX/MEM datapath slice.
// master: the upstream stage driving operands and controls.
// slave:  the datapath returning ALU and memory results.
interface ex_mem_datapath_if;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;

    modport master (
        output alu_op, funct, operand_a, operand_b, mem_read, mem_write, write_data,
        input  alu_ctrl, alu_result, zero, read_data
    );

    modport slave (
        input  alu_op, funct, operand_a, operand_b, mem_read, mem_write, write_data,
        output alu_ctrl, alu_result, zero, read_data
    );
endinterface

// File: rtl/ex_mem_datapath.sv
// Execute/memory slice of the 5-stage MIPS pipeline: ALU control decode,
// 32-bit ALU, and a word-organised data memory addressed by the ALU result.
module ex_mem_datapath #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_mem_datapath_if.slave bus
);

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_XOR = 4'b0011,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100
    } alu_ctrl_e;

    alu_ctrl_e   ctrl;
    logic [31:0] result;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;

    // ALU control decode from ALUOp and funct
    always_comb begin
        ctrl = CTRL_ADD;
        case (bus.alu_op)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b11: ctrl = CTRL_OR;
            default: begin
                case (bus.funct)
                    6'b100000: ctrl = CTRL_ADD;
                    6'b100010: ctrl = CTRL_SUB;
                    6'b100100: ctrl = CTRL_AND;
                    6'b100101: ctrl = CTRL_OR;
                    6'b100110: ctrl = CTRL_XOR;
                    6'b100111: ctrl = CTRL_NOR;
                    6'b101010: ctrl = CTRL_SLT;
                    default:   ctrl = CTRL_ADD;
                endcase
            end
        endcase
    end

    // 32-bit ALU, modulo-2^32 arithmetic with no overflow flag
    always_comb begin
        result = '0;
        case (ctrl)
            CTRL_AND: result = bus.operand_a & bus.operand_b;
            CTRL_OR:  result = bus.operand_a | bus.operand_b;
            CTRL_ADD: result = bus.operand_a + bus.operand_b;
            CTRL_SUB: result = bus.operand_a - bus.operand_b;
            CTRL_XOR: result = bus.operand_a ^ bus.operand_b;
            CTRL_NOR: result = ~(bus.operand_a | bus.operand_b);
            CTRL_SLT: result = {31'd0, $signed(bus.operand_a) < $signed(bus.operand_b)};
            default:  result = '0;
        endcase
    end

    // Byte address -> word index; low two bits and bits above the array wrap away
    assign idx = result[AW+1:2];

    // Data memory: async clear on reset, word write on rising edge otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.mem_write) begin
            mem[idx] <= bus.write_data;
        end
    end

    assign bus.alu_ctrl   = ctrl;
    assign bus.alu_result = result;
    assign bus.zero       = (result == 32'd0);
    assign bus.read_data  = (rst_n && bus.mem_read) ? mem[idx] : '0;

endmodule

// File: tb/tb_ex_mem_datapath.sv
// Directed-vector bench for ex_mem_datapath: ALU decode/compute, memory
// store/load, address aliasing, read-during-write and asynchronous reset.
module tb_ex_mem_datapath;

    logic clk;
    logic rst_n;
    int unsigned vectors;
    int unsigned miscompares;

    ex_mem_datapath_if bus ();

    ex_mem_datapath #(.DEPTH(64), .AW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op    = op;
        bus.funct     = f;
        bus.operand_a = a;
        bus.operand_b = b;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        bus.write_data = 32'h0;
        drive(2'b00, 6'd0, 32'h100, 32'h8);
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read_data got %h want %h", bus.read_data, 32'h0);
        end
        vectors++;
        if (bus.alu_result !== 32'h108) begin
            miscompares++;
            $display("FAIL reset_alu_live got %h want %h", bus.alu_result, 32'h108);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_alu_decode;
        drive(2'b10, 6'b100000, 32'd7, 32'd5);
        vectors++;
        if (bus.alu_ctrl !== 4'b0010 || bus.alu_result !== 32'd12 || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL add_7_5 got ctrl=%b res=%h z=%b want 0010/0000000c/0",
                     bus.alu_ctrl, bus.alu_result, bus.zero);
        end
        drive(2'b10, 6'b100010, 32'd5, 32'd5);
        vectors++;
        if (bus.alu_ctrl !== 4'b0110 || bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_5_5 got ctrl=%b res=%h z=%b want 0110/00000000/1",
                     bus.alu_ctrl, bus.alu_result, bus.zero);
        end
        drive(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
        vectors++;
        if (bus.alu_ctrl !== 4'b0000 || bus.alu_result !== 32'h00F0_1200) begin
            miscompares++;
            $display("FAIL and got ctrl=%b res=%h want 0000/00f01200", bus.alu_ctrl, bus.alu_result);
        end
        drive(2'b10, 6'b100101, 32'hF000_000F, 32'h0F00_00F0);
        vectors++;
        if (bus.alu_ctrl !== 4'b0001 || bus.alu_result !== 32'hFF00_00FF) begin
            miscompares++;
            $display("FAIL or got ctrl=%b res=%h want 0001/ff0000ff", bus.alu_ctrl, bus.alu_result);
        end
        drive(2'b10, 6'b100110, 32'hAAAA_5555, 32'hFFFF_0000);
        vectors++;
        if (bus.alu_ctrl !== 4'b0011 || bus.alu_result !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL xor got ctrl=%b res=%h want 0011/55555555", bus.alu_ctrl, bus.alu_result);
        end
        drive(2'b11, 6'b000000, 32'h0000_1200, 32'h0000_0034);
        vectors++;
        if (bus.alu_ctrl !== 4'b0001 || bus.alu_result !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL ori got ctrl=%b res=%h want 0001/00001234", bus.alu_ctrl, bus.alu_result);
        end
    endtask

    task automatic test_slt_nor;
        drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        vectors++;
        if (bus.alu_ctrl !== 4'b0111 || bus.alu_result !== 32'd1) begin
            miscompares++;
            $display("FAIL slt_neg1_lt_1 got ctrl=%b res=%h want 0111/00000001", bus.alu_ctrl, bus.alu_result);
        end
        drive(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
        vectors++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL slt_1_lt_neg1 got res=%h z=%b want 00000000/1", bus.alu_result, bus.zero);
        end
        drive(2'b10, 6'b100111, 32'd0, 32'd0);
        vectors++;
        if (bus.alu_ctrl !== 4'b1100 || bus.alu_result !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL nor_0_0 got ctrl=%b res=%h want 1100/ffffffff", bus.alu_ctrl, bus.alu_result);
        end
    endtask

    task automatic test_wrap;
        drive(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1);
        vectors++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL add_wrap got res=%h z=%b want 00000000/1", bus.alu_result, bus.zero);
        end
        drive(2'b01, 6'b100000, 32'd3, 32'd3);
        vectors++;
        if (bus.alu_ctrl !== 4'b0110 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_sub got ctrl=%b z=%b want 0110/1", bus.alu_ctrl, bus.zero);
        end
        drive(2'b01, 6'b100000, 32'd2, 32'd3);
        vectors++;
        if (bus.alu_result !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_wrap got res=%h z=%b want ffffffff/0", bus.alu_result, bus.zero);
        end
        drive(2'b10, 6'b111111, 32'd10, 32'd20);
        vectors++;
        if (bus.alu_ctrl !== 4'b0010 || bus.alu_result !== 32'd30) begin
            miscompares++;
            $display("FAIL unknown_funct got ctrl=%b res=%h want 0010/0000001e", bus.alu_ctrl, bus.alu_result);
        end
        drive(2'b00, 6'b100010, 32'd10, 32'd20);
        vectors++;
        if (bus.alu_ctrl !== 4'b0010 || bus.alu_result !== 32'd30) begin
            miscompares++;
            $display("FAIL aluop00_ignores_funct got ctrl=%b res=%h want 0010/0000001e", bus.alu_ctrl, bus.alu_result);
        end
    endtask

    task automatic test_store_load;
        @(negedge clk);
        drive(2'b00, 6'd0, 32'h100, 32'h8);
        bus.write_data = 32'hDEAD_BEEF;
        bus.mem_write  = 1'b1;
        bus.mem_read   = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        #1;
        vectors++;
        if (bus.read_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_after_store got %h want deadbeef", bus.read_data);
        end
        bus.mem_read = 1'b0;
        #1;
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL read_disabled got %h want 00000000", bus.read_data);
        end
        bus.mem_read = 1'b1;
        drive(2'b00, 6'd0, 32'h100, 32'hC);
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL neighbour_untouched got %h want 00000000", bus.read_data);
        end
    endtask

    task automatic test_alias;
        bus.mem_read = 1'b1;
        drive(2'b00, 6'd0, 32'h100, 32'hA);
        vectors++;
        if (bus.read_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alias_10a got %h want deadbeef", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h200, 32'h8);
        vectors++;
        if (bus.read_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alias_208 got %h want deadbeef", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h0, 32'h8);
        vectors++;
        if (bus.read_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alias_008 got %h want deadbeef", bus.read_data);
        end
    endtask

    task automatic test_back_to_back;
        // Two writes on consecutive edges to different words, then read-during-write.
        @(negedge clk);
        drive(2'b00, 6'd0, 32'h40, 32'h0);
        bus.write_data = 32'h1111_1111;
        bus.mem_write  = 1'b1;
        @(negedge clk);
        drive(2'b00, 6'd0, 32'h44, 32'h0);
        bus.write_data = 32'h2222_2222;
        @(negedge clk);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        drive(2'b00, 6'd0, 32'h40, 32'h0);
        vectors++;
        if (bus.read_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL b2b_word16 got %h want 11111111", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h44, 32'h0);
        vectors++;
        if (bus.read_data !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL b2b_word17 got %h want 22222222", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h40, 32'h0);
        bus.write_data = 32'h3333_3333;
        bus.mem_write  = 1'b1;
        #1;
        vectors++;
        if (bus.read_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL rdw_before_edge got %h want 11111111", bus.read_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.read_data !== 32'h3333_3333) begin
            miscompares++;
            $display("FAIL rdw_after_edge got %h want 33333333", bus.read_data);
        end
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset_clear;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.mem_read = 1'b1;
        drive(2'b00, 6'd0, 32'h100, 32'h8);
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_midcycle got %h want 00000000", bus.read_data);
        end
        // Write attempt across an edge while reset is held.
        bus.write_data = 32'hCAFE_F00D;
        bus.mem_write  = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL write_under_reset got %h want 00000000", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h40, 32'h0);
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL word16_cleared got %h want 00000000", bus.read_data);
        end
        drive(2'b00, 6'd0, 32'h44, 32'h0);
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL word17_cleared got %h want 00000000", bus.read_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.alu_op  = 2'b00;
        bus.funct   = 6'd0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.write_data = 32'h0;
        test_reset();
        test_alu_decode();
        test_slt_nor();
        test_wrap();
        test_store_load();
        test_alias();
        test_back_to_back();
        test_reset_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got stalled want finish");
        $fatal(1, "timeout");
    end

endmodule
